cp0_exception_sequencer: RTL and testbench

- Sequences precise exception entry, interrupt entry and ERET return for the CPU, using coprocessor 0's single write port.
- Arbitrates that write port between itself and WB-stage MTC0 writes.
- Sits beside the memory-access stage. Consumes its exception request and the forwarded CP0 status/EPC values; drives pipeline flush/stall and PC redirect to fetch.

---
 rtl/cp0_exception_sequencer.sv | 164 ++++++++++++++++
 tb/tb_cp0_exception_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_sequencer.sv
// CP0 exception/interrupt entry and ERET sequencer.
// Owns the CP0 write port outside IDLE; grants it to WB MTC0 in IDLE.
module cp0_exception_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR = 16'h0040
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [ADDR_WIDTH-1:0] exc_pc,
  input  logic                  exc_bd,
  input  logic                  eret_valid,
  input  logic [5:0]            hw_int,
  input  logic [DATA_WIDTH-1:0] cp0_status,
  input  logic [ADDR_WIDTH-1:0] cp0_epc,
  input  logic                  wb_cp0_req,
  input  logic [4:0]            wb_cp0_addr,
  input  logic [DATA_WIDTH-1:0] wb_cp0_data,
  output logic                  wb_cp0_ready,
  output logic                  cp0_we,
  output logic [4:0]            cp0_waddr,
  output logic [DATA_WIDTH-1:0] cp0_wdata,
  output logic                  flush,
  output logic                  stall,
  output logic                  pc_redirect,
  output logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_EPC    = 3'd1;
  localparam logic [2:0] S_CAUSE  = 3'd2;
  localparam logic [2:0] S_STATUS = 3'd3;
  localparam logic [2:0] S_ERET   = 3'd4;
  localparam logic [2:0] S_REDIR  = 3'd5;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  logic [2:0]            r_state;
  logic [4:0]            r_code;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_bd;
  logic [5:0]            r_hw;
  logic [DATA_WIDTH-1:0] r_status;
  logic [ADDR_WIDTH-1:0] r_epc;
  logic                  r_eret;

  logic                  w_idle;
  logic                  w_wb_fire;
  logic                  w_int_pend;
  logic                  w_exc_evt;
  logic [DATA_WIDTH-1:0] w_status_l;
  logic [ADDR_WIDTH-1:0] w_epc_l;
  logic [ADDR_WIDTH-1:0] w_epc_val;
  logic [DATA_WIDTH-1:0] w_cause;

  assign w_idle     = (r_state == S_IDLE);
  assign w_wb_fire  = w_idle & wb_cp0_req;
  assign w_int_pend = cp0_status[0] & ~cp0_status[1]
                    & |(hw_int & cp0_status[15:10]);
  assign w_exc_evt  = exc_valid | w_int_pend;

  // The granted WB write is older, so its value is what the sequence must see.
  assign w_status_l = (w_wb_fire && wb_cp0_addr == A_STATUS)
                    ? wb_cp0_data : cp0_status;
  assign w_epc_l    = (w_wb_fire && wb_cp0_addr == A_EPC)
                    ? wb_cp0_data[ADDR_WIDTH-1:0] : cp0_epc;

  assign w_epc_val  = r_bd ? (r_pc - ADDR_WIDTH'(4)) : r_pc;

  always_comb begin
    w_cause = '0;
    w_cause[DATA_WIDTH-1] = r_bd;
    w_cause[15:10] = r_hw;
    w_cause[6:2] = r_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_code   <= '0;
      r_pc     <= '0;
      r_bd     <= 1'b0;
      r_hw     <= '0;
      r_status <= '0;
      r_epc    <= '0;
      r_eret   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_exc_evt || eret_valid) begin
            r_code   <= exc_valid ? exc_code : 5'd0;
            r_pc     <= exc_pc;
            r_bd     <= exc_bd;
            r_hw     <= hw_int;
            r_status <= w_status_l;
            r_epc    <= w_epc_l;
            r_eret   <= ~w_exc_evt;
            r_state  <= w_exc_evt ? S_EPC : S_ERET;
          end
        end
        S_EPC:    r_state <= S_CAUSE;
        S_CAUSE:  r_state <= S_STATUS;
        S_STATUS: r_state <= S_REDIR;
        S_ERET:   r_state <= S_REDIR;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    wb_cp0_ready = 1'b0;
    cp0_we       = 1'b0;
    cp0_waddr    = '0;
    cp0_wdata    = '0;
    flush        = 1'b0;
    pc_redirect  = 1'b0;
    pc_target    = '0;
    busy         = ~w_idle;
    stall        = ~w_idle;
    case (r_state)
      S_IDLE: begin
        wb_cp0_ready = 1'b1;
        if (wb_cp0_req) begin
          cp0_we    = 1'b1;
          cp0_waddr = wb_cp0_addr;
          cp0_wdata = wb_cp0_data;
        end
      end
      S_EPC: begin
        flush     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = A_EPC;
        cp0_wdata = DATA_WIDTH'(w_epc_val);
      end
      S_CAUSE: begin
        cp0_we    = 1'b1;
        cp0_waddr = A_CAUSE;
        cp0_wdata = w_cause;
      end
      S_STATUS: begin
        cp0_we    = 1'b1;
        cp0_waddr = A_STATUS;
        cp0_wdata = r_status | DATA_WIDTH'(2);
      end
      S_ERET: begin
        flush     = 1'b1;
        cp0_we    = 1'b1;
        cp0_waddr = A_STATUS;
        cp0_wdata = r_status & ~DATA_WIDTH'(2);
      end
      S_REDIR: begin
        pc_redirect = 1'b1;
        pc_target   = r_eret ? r_epc : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_sequencer.sv
// Scoreboard bench for cp0_exception_sequencer against a CP0 register model.
// Expected writes/redirects are queued at stimulus time and popped by a monitor.
module tb_cp0_exception_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [15:0] exc_pc;
  logic        exc_bd;
  logic        eret_valid;
  logic [5:0]  hw_int;
  logic [31:0] cp0_status;
  logic [15:0] cp0_epc;
  logic        wb_cp0_req;
  logic [4:0]  wb_cp0_addr;
  logic [31:0] wb_cp0_data;
  logic        wb_cp0_ready;
  logic        cp0_we;
  logic [4:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush;
  logic        stall;
  logic        pc_redirect;
  logic [15:0] pc_target;
  logic        busy;

  always #5 clk = ~clk;

  cp0_exception_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .exc_pc(exc_pc), .exc_bd(exc_bd),
    .eret_valid(eret_valid), .hw_int(hw_int),
    .cp0_status(cp0_status), .cp0_epc(cp0_epc),
    .wb_cp0_req(wb_cp0_req), .wb_cp0_addr(wb_cp0_addr),
    .wb_cp0_data(wb_cp0_data), .wb_cp0_ready(wb_cp0_ready),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .flush(flush), .stall(stall),
    .pc_redirect(pc_redirect), .pc_target(pc_target),
    .busy(busy)
  );

  typedef struct {
    bit        redir;
    bit [4:0]  addr;
    bit [31:0] data;
    bit [15:0] tgt;
    bit        flush;
  } exp_t;

  exp_t        sbq[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit [31:0]   regs[32];
  bit          mon_en = 1'b0;
  bit          exp_busy = 1'b0;
  bit          pend_req = 1'b0;
  bit [4:0]    pend_addr;
  bit [31:0]   pend_data;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic push(input bit rd, input bit [4:0] a, input bit [31:0] d,
                      input bit [15:0] t, input bit f);
    exp_t e;
    e.redir = rd; e.addr = a; e.data = d; e.tgt = t; e.flush = f;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(exp_busy));
      check("stall", 32'(stall), 32'(exp_busy));
      check("wb_ready", 32'(wb_cp0_ready), 32'(!exp_busy));
      if (pc_redirect || cp0_we) begin
        if (sbq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_output: we=%b addr=%0d data=%h redir=%b tgt=%h, required none",
                   cp0_we, cp0_waddr, cp0_wdata, pc_redirect, pc_target);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          if (e.redir) begin
            check("redirect", 32'(pc_redirect), 32'd1);
            check("pc_target", 32'(pc_target), 32'(e.tgt));
            check("we_in_redirect", 32'(cp0_we), 32'd0);
            check("flush_in_redirect", 32'(flush), 32'd0);
          end else begin
            check("we", 32'(cp0_we), 32'd1);
            check("redir_on_write", 32'(pc_redirect), 32'd0);
            check("waddr", 32'(cp0_waddr), 32'(e.addr));
            check("wdata", cp0_wdata, e.data);
            check("flush", 32'(flush), 32'(e.flush));
          end
        end
      end else begin
        check("flush_quiet", 32'(flush), 32'd0);
      end
    end
  end

  task automatic idle_inputs();
    exc_valid = 0; exc_code = 0; exc_pc = 0; exc_bd = 0;
    eret_valid = 0; hw_int = 0;
    cp0_status = regs[12]; cp0_epc = regs[14][15:0];
  endtask

  task automatic check_reset_outputs();
    check("rst_we", 32'(cp0_we), 32'd0);
    check("rst_waddr", 32'(cp0_waddr), 32'd0);
    check("rst_wdata", cp0_wdata, 32'd0);
    check("rst_flush", 32'(flush), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_redirect", 32'(pc_redirect), 32'd0);
    check("rst_target", 32'(pc_target), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
  endtask

  // One IDLE-cycle stimulus plus the whole sequence it triggers.
  task automatic txn(input bit exc, input bit [4:0] code, input bit [15:0] pc,
                     input bit bd, input bit eret, input bit [5:0] hw,
                     input bit wreq, input bit [4:0] wa, input bit [31:0] wd,
                     input bit wb_busy);
    bit [31:0] st, stf, epf, cause;
    bit [15:0] e;
    bit [4:0]  c;
    bit        ip;
    int        len;
    if (pend_req) begin
      wreq = 1; wa = pend_addr; wd = pend_data; pend_req = 0;
    end
    exc_valid = exc; exc_code = code; exc_pc = pc; exc_bd = bd;
    eret_valid = eret; hw_int = hw;
    cp0_status = regs[12]; cp0_epc = regs[14][15:0];
    wb_cp0_req = wreq; wb_cp0_addr = wa; wb_cp0_data = wd;
    st = regs[12];
    if (wreq) push(0, wa, wd, 0, 0);
    stf = (wreq && wa == 5'd12) ? wd : st;
    epf = (wreq && wa == 5'd14) ? wd : regs[14];
    if (wreq) regs[wa] = wd;
    ip = st[0] && !st[1] && ((hw & st[15:10]) != 0);
    len = 0;
    if (exc || ip) begin
      c = exc ? code : 5'd0;
      e = bd ? pc - 16'd4 : pc;
      cause = 0;
      cause[31] = bd; cause[15:10] = hw; cause[6:2] = c;
      push(0, 5'd14, {16'h0, e}, 0, 1);
      push(0, 5'd13, cause, 0, 0);
      push(0, 5'd12, stf | 32'h2, 0, 0);
      push(1, 0, 0, 16'h0040, 0);
      regs[14] = {16'h0, e}; regs[13] = cause; regs[12] = stf | 32'h2;
      len = 4;
    end else if (eret) begin
      push(0, 5'd12, stf & ~32'h2, 0, 1);
      push(1, 0, 0, epf[15:0], 0);
      regs[12] = stf & ~32'h2;
      len = 2;
    end
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      exp_busy = 1;
      wb_cp0_req = 0;
      if (wb_busy) begin
        if (!pend_req) begin
          pend_req = 1;
          pend_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(12, 14))
                                                   : 5'($urandom_range(0, 31));
          pend_data = $urandom;
        end
        wb_cp0_req = 1; wb_cp0_addr = pend_addr; wb_cp0_data = pend_data;
      end
      exc_valid = 1'($urandom); eret_valid = 1'($urandom);
      exc_code = 5'($urandom); exc_pc = 16'($urandom);
      exc_bd = 1'($urandom); hw_int = 6'($urandom);
      cp0_status = $urandom; cp0_epc = 16'($urandom);
    end
    @(posedge clk); #1;
    exp_busy = 0;
    idle_inputs();
  endtask

  initial begin
    foreach (regs[i]) regs[i] = 0;
    rst_n = 0;
    wb_cp0_req = 0; wb_cp0_addr = 0; wb_cp0_data = 0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1;
    mon_en = 1;

    txn(1, 5'd4, 16'h0120, 0, 0, 0, 0, 0, 0, 0);
    txn(1, 5'd10, 16'h0124, 1, 0, 0, 0, 0, 0, 0);
    regs[12] = 32'h0000_FC01;
    txn(0, 0, 16'h0300, 0, 0, 6'b000100, 0, 0, 0, 0);
    txn(0, 0, 16'h0304, 0, 0, 6'b000100, 0, 0, 0, 0);
    txn(0, 0, 16'h0308, 0, 0, 6'b000100, 0, 0, 0, 0);
    txn(1, 5'd12, 16'h0400, 0, 1, 0, 0, 0, 0, 0);
    regs[12] = 0;
    txn(1, 5'd8, 16'h0500, 0, 0, 0, 1, 5'd12, 32'h0000_0401, 1);
    txn(0, 0, 16'h0, 0, 0, 0, 0, 0, 0, 0);
    regs[12] = 32'h3; regs[14] = 32'h0200;
    txn(0, 0, 16'h0, 0, 1, 0, 0, 0, 0, 0);
    txn(1, 5'd1, 16'h0002, 1, 0, 0, 0, 0, 0, 0);

    // Reset asserted during the Cause-write cycle: no Status write, no redirect.
    regs[12] = 32'h0000_0011;
    exc_valid = 1; exc_code = 5'd3; exc_pc = 16'h0600; exc_bd = 0;
    cp0_status = regs[12];
    push(0, 5'd14, 32'h0600, 0, 1);
    push(0, 5'd13, 32'h0000_000C, 0, 0);
    regs[14] = 32'h0600; regs[13] = 32'h0000_000C;
    @(posedge clk); #1;
    exp_busy = 1; idle_inputs();
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    exp_busy = 0;
    check_reset_outputs();
    rst_n = 1;
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0)
        regs[12] = $urandom & 32'h0000_FC03;
      if ($urandom_range(0, 5) == 0)
        regs[14] = {16'h0, 16'($urandom)};
      txn($urandom_range(0, 3) == 0, 5'($urandom), 16'($urandom),
          1'($urandom), $urandom_range(0, 3) == 0, 6'($urandom),
          $urandom_range(0, 2) == 0, 5'($urandom_range(10, 15)), $urandom,
          $urandom_range(0, 2) == 0);
    end
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    regs[12] = 0;
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    txn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
